conv_window_feeder: RTL

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

---
 rtl/conv_window_feeder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Control side of a 3x3 convolution: fetches each 3x3 window of an IMG_W x
//   IMG_H image from an external pixel memory, presents the nine weight/pixel
//   taps to a MAC unit, collects the MAC sum and hands it downstream with its
//   output row/column. Windows are produced in raster order.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begin one frame (accepted in IDLE only)
//   kw_we/kw_addr/kw_data     kernel weight write port (IDLE only, index 0..8)
//   pix_addr/pix_data         pixel memory read; data returns one cycle later
//   en/kernel_weights/in_pix  tap presented to the MAC while a window is active
//   ind                       MAC consumed the current tap
//   done/out_pix              MAC result ready / MAC result
//   ack                       one-cycle acknowledge of the MAC result
//   res_valid/res_ready       result handshake; res_data/res_row/res_col payload
//   busy                      any state other than IDLE
//   frame_done                one-cycle pulse after the last result is accepted
//   err                       sticky: done seen in FEED, or ind outside FEED
module conv_window_feeder #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kw_we,
  input  logic [3:0]        kw_addr,
  input  logic [15:0]       kw_data,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [15:0]       pix_data,
  output logic              en,
  output logic [15:0]       kernel_weights,
  output logic [15:0]       in_pix,
  input  logic              ind,
  input  logic              done,
  input  logic [31:0]       out_pix,
  output logic              ack,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [7:0]        res_row,
  output logic [7:0]        res_col,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, OUT} state_t;

  localparam logic [7:0] LAST_C = 8'(IMG_W - 3);
  localparam logic [7:0] LAST_R = 8'(IMG_H - 3);

  state_t            state_q, state_d;
  logic [15:0]       weight_q [9];
  logic [15:0]       weight_d [9];
  logic [15:0]       pix_buf_q [9];
  logic [15:0]       pix_buf_d [9];
  logic [3:0]        k_q, k_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              en_q, en_d, ack_q, ack_d, res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [7:0]        res_row_q, res_row_d, res_col_q, res_col_d;
  logic              busy_q, busy_d, frame_done_q, frame_done_d, err_q, err_d;
  logic [15:0]       kernel_weights_q, kernel_weights_d, in_pix_q, in_pix_d;
  logic [7:0]        r_next, c_next;

  // Address of tap t = 3i+j of the window whose origin is (r,c).
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [7:0] r,
                                                 input logic [7:0] c,
                                                 input logic [3:0] t);
    int unsigned row, col;
    row = 32'(r) + 32'(t) / 3;
    col = 32'(c) + 32'(t) % 3;
    tap_addr = ADDR_W'(row * IMG_W + col);
  endfunction

  always_comb begin
    state_d          = state_q;
    weight_d         = weight_q;
    pix_buf_d        = pix_buf_q;
    k_d              = k_q;
    cnt_d            = cnt_q;
    r_d              = r_q;
    c_d              = c_q;
    pix_addr_d       = pix_addr_q;
    en_d             = en_q;
    ack_d            = 1'b0;
    res_valid_d      = res_valid_q;
    res_data_d       = res_data_q;
    res_row_d        = res_row_q;
    res_col_d        = res_col_q;
    frame_done_d     = 1'b0;
    kernel_weights_d = kernel_weights_q;
    in_pix_d         = in_pix_q;
    err_d            = err_q | (done && state_q == FEED) | (ind && state_q != FEED);

    // Raster advance of the window origin.
    if (c_q == LAST_C) begin
      c_next = '0;
      r_next = r_q + 8'd1;
    end else begin
      c_next = c_q + 8'd1;
      r_next = r_q;
    end

    case (state_q)
      IDLE: begin
        if (kw_we && kw_addr < 4'd9) weight_d[kw_addr] = kw_data;
        if (start) begin
          r_d        = '0;
          c_d        = '0;
          cnt_d      = '0;
          pix_addr_d = tap_addr('0, '0, '0);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // cnt is the tap whose address is on pix_addr; the pixel returned this
        // cycle belongs to tap cnt-1.
        if (cnt_q != 4'd0) pix_buf_d[cnt_q - 4'd1] = pix_data;
        if (cnt_q < 4'd8) pix_addr_d = tap_addr(r_q, c_q, cnt_q + 4'd1);
        if (cnt_q == 4'd9) begin
          state_d          = FEED;
          en_d             = 1'b1;
          k_d              = '0;
          cnt_d            = '0;
          kernel_weights_d = weight_q[0];
          in_pix_d         = pix_buf_q[0];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FEED: begin
        if (ind) begin
          if (k_q == 4'd8) begin
            state_d = WAIT;
            k_d     = '0;
          end else begin
            k_d              = k_q + 4'd1;
            kernel_weights_d = weight_q[k_q + 4'd1];
            in_pix_d         = pix_buf_q[k_q + 4'd1];
          end
        end
      end
      WAIT: begin
        if (done) begin
          res_data_d  = out_pix;
          res_row_d   = r_q;
          res_col_d   = c_q;
          ack_d       = 1'b1;
          en_d        = 1'b0;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (r_q == LAST_R && c_q == LAST_C) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            r_d        = r_next;
            c_d        = c_next;
            cnt_d      = '0;
            pix_addr_d = tap_addr(r_next, c_next, '0);
            state_d    = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      weight_q         <= '{default: '0};
      pix_buf_q        <= '{default: '0};
      k_q              <= '0;
      cnt_q            <= '0;
      r_q              <= '0;
      c_q              <= '0;
      pix_addr_q       <= '0;
      en_q             <= 1'b0;
      ack_q            <= 1'b0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_row_q        <= '0;
      res_col_q        <= '0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      err_q            <= 1'b0;
      kernel_weights_q <= '0;
      in_pix_q         <= '0;
    end else begin
      state_q          <= state_d;
      weight_q         <= weight_d;
      pix_buf_q        <= pix_buf_d;
      k_q              <= k_d;
      cnt_q            <= cnt_d;
      r_q              <= r_d;
      c_q              <= c_d;
      pix_addr_q       <= pix_addr_d;
      en_q             <= en_d;
      ack_q            <= ack_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
      res_row_q        <= res_row_d;
      res_col_q        <= res_col_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      err_q            <= err_d;
      kernel_weights_q <= kernel_weights_d;
      in_pix_q         <= in_pix_d;
    end
  end

  assign pix_addr       = pix_addr_q;
  assign en             = en_q;
  assign kernel_weights = kernel_weights_q;
  assign in_pix         = in_pix_q;
  assign ack            = ack_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_row        = res_row_q;
  assign res_col        = res_col_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign err            = err_q;

endmodule
